// File: rtl/config_frame_sequencer_if.sv
// Configuration word stream handshake between the bitstream loader and the
// frame sequencer.
interface config_frame_sequencer_if;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/config_frame_sequencer.sv
// Turns a header + MaxFramesPerCol data words into per-frame writes on the
// fabric configuration chain (FrameData plus a one-hot FrameStrobe pulse).
module config_frame_sequencer #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumberOfCols    = 4
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  config_frame_sequencer_if.slave                 cfg,
  input  logic                                    err_clr,
  output logic [FrameBitsPerRow-1:0]              FrameData,
  output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                    cfg_busy,
  output logic                                    col_done,
  output logic                                    cfg_err
);

  localparam int StrobeW = NumberOfCols * MaxFramesPerCol;
  localparam int FrmW    = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int ColW    = (NumberOfCols > 1) ? $clog2(NumberOfCols) : 1;
  localparam int IdxW    = (StrobeW > 1) ? $clog2(StrobeW) : 1;

  localparam logic [7:0]      ColLimit  = 8'(NumberOfCols);
  localparam logic [FrmW-1:0] LastFrame = FrmW'(MaxFramesPerCol - 1);
  localparam logic [StrobeW-1:0] StrobeOne = {{(StrobeW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STROBE,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ColW-1:0]        col_q, col_d;
  logic [FrmW-1:0]        frame_q, frame_d;
  logic [FrameBitsPerRow-1:0] data_d;
  logic [StrobeW-1:0]     strobe_d;
  logic                   err_d;
  logic                   accept;
  logic                   header_ok;
  logic [IdxW-1:0]        strobe_idx;

  // Ready is decoded from registered state only, so no path from cfg_valid.
  assign cfg.cfg_ready = (state_q == IDLE) || (state_q == LOAD);
  assign cfg_busy      = (state_q != IDLE);
  assign col_done      = (state_q == DONE);

  assign accept    = cfg.cfg_valid & cfg.cfg_ready;
  assign header_ok = (cfg.cfg_data[31:24] == 8'hC0) && (cfg.cfg_data[7:0] < ColLimit);
  assign strobe_idx = IdxW'(col_q) * IdxW'(MaxFramesPerCol) + IdxW'(frame_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      col_q       <= '0;
      frame_q     <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      cfg_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      frame_q     <= frame_d;
      FrameData   <= data_d;
      FrameStrobe <= strobe_d;
      cfg_err     <= err_d;
    end
  end

  // A clear and a bad header in the same cycle leave the error set.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    frame_d  = frame_q;
    data_d   = FrameData;
    strobe_d = '0;
    err_d    = cfg_err;

    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (header_ok) begin
            col_d   = cfg.cfg_data[ColW-1:0];
            frame_d = '0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          data_d   = FrameBitsPerRow'(cfg.cfg_data);
          strobe_d = StrobeOne << strobe_idx;
          state_d  = STROBE;
        end
      end
      STROBE: begin
        if (frame_q == LastFrame) begin
          state_d = DONE;
        end else begin
          frame_d = frame_q + 1'b1;
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_config_frame_sequencer.sv
// Self-checking bench: a transaction-level model turns every accepted word into
// expected per-cycle strobe/done/ready/busy/err values compared each cycle.
module tb_config_frame_sequencer;

  localparam int FB = 32;
  localparam int MF = 20;
  localparam int NC = 4;
  localparam int SW = NC * MF;

  logic          CLK = 1'b0;
  logic          RST;
  logic          err_clr;
  logic [FB-1:0] FrameData;
  logic [SW-1:0] FrameStrobe;
  logic          cfg_busy;
  logic          col_done;
  logic          cfg_err;

  config_frame_sequencer_if cfg ();

  config_frame_sequencer #(
    .FrameBitsPerRow(FB),
    .MaxFramesPerCol(MF),
    .NumberOfCols   (NC)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cfg        (cfg),
    .err_clr    (err_clr),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .cfg_busy   (cfg_busy),
    .col_done   (col_done),
    .cfg_err    (cfg_err)
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  bit          m_in_col;
  int          m_col;
  int          m_n;
  logic [31:0] m_data;
  bit          m_err;
  int          exp_strobe[int];
  bit          exp_done[int];
  int          m_cols_done = 0;
  int          m_strobes   = 0;
  int          obs_done    = 0;
  int          obs_strobes = 0;

  task automatic checkOutput(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: parses the accepted word stream into column writes and
  // books the cycle each strobe / col_done is due in.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_in_col = 1'b0;
      m_n      = 0;
      m_data   = '0;
      m_err    = 1'b0;
      exp_strobe.delete();
      exp_done.delete();
    end else begin
      cyc++;
      if (err_clr) m_err = 1'b0;
      if (cfg.cfg_valid && cfg.cfg_ready) begin
        if (!m_in_col) begin
          if (cfg.cfg_data[31:24] == 8'hC0 && int'(cfg.cfg_data[7:0]) < NC) begin
            m_in_col = 1'b1;
            m_col    = int'(cfg.cfg_data[7:0]);
            m_n      = 0;
          end else begin
            m_err = 1'b1;
          end
        end else begin
          exp_strobe[cyc] = m_col * MF + m_n;
          m_data = cfg.cfg_data;
          m_n++;
          m_strobes++;
          if (m_n == MF) begin
            m_in_col = 1'b0;
            exp_done[cyc + 1] = 1'b1;
            m_cols_done++;
          end
        end
      end
    end
  end

  always @(negedge CLK) begin
    bit strobe_now;
    bit done_now;
    logic [SW-1:0] es;
    strobe_now = exp_strobe.exists(cyc);
    done_now   = exp_done.exists(cyc);
    es = '0;
    if (strobe_now) es = SW'(1) << exp_strobe[cyc];
    checkOutput("strobe", FrameStrobe, es);
    checkOutput("frame_data", SW'(FrameData), SW'(m_data));
    checkOutput("col_done", SW'(col_done), SW'(done_now));
    checkOutput("ready", SW'(cfg.cfg_ready), SW'(!(strobe_now || done_now)));
    checkOutput("busy", SW'(cfg_busy), SW'(m_in_col || strobe_now || done_now));
    checkOutput("err", SW'(cfg_err), SW'(m_err));
    if (FrameStrobe != '0) obs_strobes++;
    if (col_done) obs_done++;
  end

  // Presents one word (after optional idle gap) and holds it until accepted.
  task automatic applyStimulus(input logic [31:0] w, input int gap);
    int waited;
    repeat (gap) begin
      cfg.cfg_valid = 1'b0;
      @(negedge CLK);
    end
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = w;
    waited = 0;
    while (!cfg.cfg_ready && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    checkOutput("ready_wait_timeout", SW'(waited >= 50), '0);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    cfg.cfg_valid = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic [31:0] header(input int col);
    logic [31:0] h;
    h = {8'hC0, 16'($urandom), 8'(col)};
    return h;
  endfunction

  initial begin
    RST           = 1'b1;
    err_clr       = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = '0;
    #1;
    checkOutput("rst_strobe", FrameStrobe, '0);
    checkOutput("rst_ready", SW'(cfg.cfg_ready), SW'(1));
    checkOutput("rst_busy", SW'(cfg_busy), '0);
    checkOutput("rst_data", SW'(FrameData), '0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    $display("[TB] full column 2");
    applyStimulus(32'hC000_0002, 0);
    for (int i = 0; i < MF; i++) applyStimulus(32'hA500_0000 + 32'(i), 0);
    idle(4);

    $display("[TB] bad headers and error clear");
    applyStimulus(32'hB000_0000, 0);
    idle(2);
    applyStimulus(32'hC000_0004, 0);
    idle(2);
    applyStimulus({8'hC0, 16'($urandom), 8'(4 + $urandom_range(0, 251))}, 1);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    idle(2);
    applyStimulus({8'(8'hC1 + $urandom_range(0, 62)), 24'($urandom)}, 0);
    err_clr = 1'b1;
    applyStimulus(32'hC000_00FF, 0);
    err_clr = 1'b0;
    idle(2);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
    idle(1);

    $display("[TB] column 0 with random gaps");
    applyStimulus(header(0), $urandom_range(0, 3));
    for (int i = 0; i < MF; i++) applyStimulus($urandom, $urandom_range(0, 3));
    idle(4);

    $display("[TB] reset during frame 7 strobe");
    applyStimulus(header(1), 0);
    for (int i = 0; i < 8; i++) applyStimulus($urandom, 0);
    cfg.cfg_valid = 1'b0;
    checkOutput("pre_rst_strobe", FrameStrobe, SW'(1) << (1 * MF + 7));
    #1 RST = 1'b1;
    #1;
    checkOutput("async_rst_strobe", FrameStrobe, '0);
    checkOutput("async_rst_ready", SW'(cfg.cfg_ready), SW'(1));
    checkOutput("async_rst_busy", SW'(cfg_busy), '0);
    checkOutput("async_rst_data", SW'(FrameData), '0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    applyStimulus(header(1), 1);
    for (int i = 0; i < MF; i++) applyStimulus($urandom, 0);
    idle(4);

    $display("[TB] back-to-back columns 0 and 3");
    applyStimulus(header(0), 0);
    for (int i = 0; i < MF; i++) applyStimulus($urandom, 0);
    applyStimulus(header(3), 0);
    for (int i = 0; i < MF; i++) applyStimulus($urandom, 0);
    idle(5);

    checkOutput("col_done_count", SW'(obs_done), SW'(m_cols_done));
    checkOutput("strobe_count", SW'(obs_strobes), SW'(m_strobes));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
